// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ writeback sources.
// One-cycle registered write command, illegal-address pulse and per-register written mask.
module regfile_write_arbiter #(
  parameter int N_REQ    = 3,
  parameter int NUM_REGS = 16,
  parameter int AW       = 4,
  parameter int DW       = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  hold,
  input  logic                  mask_clr,
  output logic                  wr_enable,
  output logic [AW-1:0]         wr_address,
  output logic [DW-1:0]         bus_data_in,
  output logic [2:0]            grant_id,
  output logic                  err_addr,
  output logic [NUM_REGS-1:0]   written_mask
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AW:0] NREG_W = (AW+1)'(NUM_REGS);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_W);
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
    return (g == PW'(N_REQ-1)) ? '0 : g + PW'(1);
  endfunction

  logic [PW-1:0]  ptr;
  logic           gnt_found;
  logic [PW-1:0]  gnt_idx;
  logic           xfer_p0;
  logic [AW-1:0]  addr_p0;
  logic [DW-1:0]  data_p0;
  logic           legal_p0;
  logic [NUM_REGS-1:0] mask_nxt;

  logic           vld_p1;
  logic [AW-1:0]  addr_p1;
  logic [DW-1:0]  data_p1;
  logic [2:0]     gid_p1;
  logic           err_p1;

  // Stage p0: round-robin pick starting at ptr, handshake and command selection
  always_comb begin
    int idx_v;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx_v     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = (int'(ptr) + k) % N_REQ;
      if (!gnt_found && req_valid[idx_v]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(idx_v);
      end
    end
  end

  assign xfer_p0  = gnt_found & ~hold & clr;
  assign addr_p0  = req_addr[int'(gnt_idx)*AW +: AW];
  assign data_p0  = req_data[int'(gnt_idx)*DW +: DW];
  assign legal_p0 = addr_ok(addr_p0);

  always_comb begin
    req_ready = '0;
    if (xfer_p0) req_ready[gnt_idx] = 1'b1;
  end

  // The clear applies first so a write landing in the same cycle survives it
  always_comb begin
    mask_nxt = mask_clr ? '0 : written_mask;
    if (xfer_p0 && legal_p0) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (addr_p0 == AW'(r)) mask_nxt[r] = 1'b1;
      end
    end
  end

  // Stage p1: registered write command to the register file
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ptr          <= '0;
      vld_p1       <= 1'b0;
      err_p1       <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
      gid_p1       <= '0;
      written_mask <= '0;
    end else begin
      vld_p1       <= xfer_p0 & legal_p0;
      err_p1       <= xfer_p0 & ~legal_p0;
      written_mask <= mask_nxt;
      if (xfer_p0) ptr <= ptr_after(gnt_idx);
      if (xfer_p0 && legal_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
        gid_p1  <= 3'(gnt_idx);
      end
    end
  end

  assign wr_enable   = vld_p1;
  assign wr_address  = addr_p1;
  assign bus_data_in = data_p1;
  assign grant_id    = gid_p1;
  assign err_addr    = err_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (N_REQ=3, NUM_REGS=12): expected write
// commands are queued as requests are driven and compared after the next clock edge.
module tb_regfile_write_arbiter;

  localparam int N_REQ = 3;
  localparam int NUM_REGS = 12;
  localparam int AW = 4;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 clr;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*AW-1:0]  req_addr;
  logic [N_REQ*DW-1:0]  req_data;
  logic [N_REQ-1:0]     req_ready;
  logic                 hold;
  logic                 mask_clr;
  logic                 wr_enable;
  logic [AW-1:0]        wr_address;
  logic [DW-1:0]        bus_data_in;
  logic [2:0]           grant_id;
  logic                 err_addr;
  logic [NUM_REGS-1:0]  written_mask;

  regfile_write_arbiter #(.N_REQ(N_REQ), .NUM_REGS(NUM_REGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .mask_clr(mask_clr),
    .wr_enable(wr_enable), .wr_address(wr_address), .bus_data_in(bus_data_in),
    .grant_id(grant_id), .err_addr(err_addr), .written_mask(written_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                en;
    logic                err;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       data;
    logic [2:0]          gid;
    logic [NUM_REGS-1:0] mask;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  int                  ptr_m;
  logic [NUM_REGS-1:0] mask_m;
  logic [AW-1:0]       last_addr;
  logic [DW-1:0]       last_data;
  logic [2:0]          last_gid;
  logic                found_m;
  int                  g_m;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    ptr_m = 0; mask_m = '0; last_addr = '0; last_data = '0; last_gid = '0;
    found_m = 1'b0; g_m = 0;
    exp_q.delete();
  endtask

  // Called just after a falling edge; returns just after the following falling edge.
  task automatic step(input logic [2:0] v,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic h, input logic mc);
    logic [AW-1:0] aa[3];
    logic [DW-1:0] dd[3];
    logic [2:0]    exp_rdy;
    exp_t          e;
    exp_t          o;
    aa[0] = a0; aa[1] = a1; aa[2] = a2;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    hold      = h;
    mask_clr  = mc;
    #1;
    found_m = 1'b0;
    g_m = 0;
    if (!h) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found_m && v[(ptr_m + k) % N_REQ]) begin
          found_m = 1'b1;
          g_m = (ptr_m + k) % N_REQ;
        end
      end
    end
    exp_rdy = found_m ? 3'(1 << g_m) : 3'b000;
    check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (mc) mask_m = '0;
    e.en = 1'b0;
    e.err = 1'b0;
    if (found_m) begin
      ptr_m = (g_m + 1) % N_REQ;
      if (aa[g_m] < AW'(NUM_REGS)) begin
        e.en = 1'b1;
        last_addr = aa[g_m];
        last_data = dd[g_m];
        last_gid = 3'(g_m);
        mask_m[aa[g_m]] = 1'b1;
      end else begin
        e.err = 1'b1;
      end
    end
    e.addr = last_addr; e.data = last_data; e.gid = last_gid; e.mask = mask_m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      o = exp_q.pop_front();
      check_val("wr_enable",    64'(wr_enable),    64'(o.en));
      check_val("err_addr",     64'(err_addr),     64'(o.err));
      check_val("wr_address",   64'(wr_address),   64'(o.addr));
      check_val("bus_data_in",  64'(bus_data_in),  64'(o.data));
      check_val("grant_id",     64'(grant_id),     64'(o.gid));
      check_val("written_mask", 64'(written_mask), 64'(o.mask));
    end
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_wr_enable"},   64'(wr_enable),    64'd0);
    check_val({tag, "_wr_address"},  64'(wr_address),   64'd0);
    check_val({tag, "_bus_data"},    64'(bus_data_in),  64'd0);
    check_val({tag, "_grant_id"},    64'(grant_id),     64'd0);
    check_val({tag, "_err_addr"},    64'(err_addr),     64'd0);
    check_val({tag, "_mask"},        64'(written_mask), 64'd0);
    check_val({tag, "_ready"},       64'(req_ready),    64'd0);
  endtask

  logic [2:0]    sv;
  logic [AW-1:0] sa[3];
  logic [DW-1:0] sd[3];

  initial begin
    clr = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; hold = 1'b0; mask_clr = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    clr = 1'b1;

    // Fairness from pointer 0: grants 0,1,2,0,1,2 with no bubbles
    for (int i = 0; i < 6; i++)
      step(3'b111, 4'(i), 4'(i+1), 4'(i+2), 32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 1'b0, 1'b0);

    step(3'b010, 4'd0, 4'd5, 4'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    step(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // One grant, then three frozen cycles, then resume at the saved pointer
    step(3'b111, 4'd7, 4'd8, 4'd9, 32'hA0, 32'hA1, 32'hA2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(3'b111, 4'd7, 4'd8, 4'd9, 32'hA0, 32'hA1, 32'hA2, 1'b1, 1'b0);
    step(3'b111, 4'd7, 4'd8, 4'd9, 32'hA0, 32'hA1, 32'hA2, 1'b0, 1'b0);

    step(3'b100, 4'd0, 4'd0, 4'd13, 32'h0, 32'h0, 32'hBAD, 1'b0, 1'b0);
    step(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    step(3'b001, 4'd3, 4'd0, 4'd0, 32'h33, 32'h0, 32'h0, 1'b0, 1'b1);
    step(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Randomised traffic; a source keeps its request stable until it is granted
    sv = '0;
    for (int i = 0; i < 3; i++) begin sa[i] = '0; sd[i] = '0; end
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!sv[i] || (found_m && g_m == i)) begin
          sv[i] = 1'($urandom_range(0, 1));
          sa[i] = 4'($urandom_range(0, 15));
          sd[i] = $urandom;
        end
      end
      step(sv, sa[0], sa[1], sa[2], sd[0], sd[1], sd[2],
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    step(3'b111, 4'd1, 4'd2, 4'd4, 32'h11, 32'h22, 32'h44, 1'b0, 1'b0);
    // Asynchronous reset in the middle of a cycle with traffic pending
    req_valid = 3'b111;
    #2 clr = 1'b0;
    #1 check_zero_outputs("midreset");
    @(negedge clk);
    clr = 1'b1;
    reset_model();
    step(3'b111, 4'd6, 4'd2, 4'd4, 32'h66, 32'h22, 32'h44, 1'b0, 1'b0);
    step(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
